alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Parametrised, registered ALU with a valid/ready handshake on both sides.
//  Sits between the register-file read stage and write-back of the datapath.
//  Single-cycle logic/arith/shift ops; iterative multi-cycle multiply.
//  Correct signed overflow, carry flag and unsigned compare.
// PARAMETERS
//  WIDTH   32  operand/result width, >=4, power of 2
//  MUL_EN  1   1: MUL implemented; 0: code 1000 treated as illegal
// PORTS
//  clk               in   1      single clock, rising edge
//  reset             in   1      asynchronous, active-high
//  in_valid          in   1      op1/op2/alu_control_code valid
//  in_ready          out  1      block accepts request this cycle
//  op1, op2          in   WIDTH  operands
//  alu_control_code  in   4      operation select
//  out_valid         out  1      result/flags valid
//  out_ready         in   1      consumer takes result this cycle
//  result            out  WIDTH  registered result
//  v_flag, n_flag    out  1      signed overflow; result[WIDTH-1]
//  z_flag, c_flag    out  1      result==0; carry / no-borrow
//  ill_flag          out  1      illegal code in this response
// BEHAVIOUR
//  Reset: all outputs 0, in_ready 1 after release, FSM IDLE, any multiply aborted.
//  Accept = in_valid & in_ready; in_ready = (state==IDLE) & (~out_valid | out_ready).
//  Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, n^v of SUB),
//   1010 SLTU, 1001 NOR, 1100 NAND, 1101 XOR, 0011 SLL, 0100 SRL, 0101 SRA
//   (shift amount = op2[$clog2(WIDTH)-1:0]), 1000 MUL (low WIDTH bits),
//   1111 NOP (result and flags re-issued unchanged). Others: result 0, ill_flag 1.
//  Latency: single-cycle ops -> out_valid the cycle after accept.
//   MUL -> exactly WIDTH+1 cycles after accept; in_ready 0 meanwhile.
//  FSM: IDLE -(accept MUL)-> MUL -(count==WIDTH-1)-> IDLE, loading output regs.
//   MUL: shift-add, one multiplier bit per cycle, counter 0..WIDTH-1.
//  Flags, computed on the final result:
//   ADD: v = a_msb==b_msb & r_msb!=a_msb; c = carry out.
//   SUB/SLT/SLTU: v = a_msb!=b_msb & r_msb!=a_msb of the difference; c = (op1>=op2 unsigned).
//   SLT/SLTU report v, c of the difference; n, z of the 0/1 result.
//   MUL: v = upper WIDTH bits of the full product nonzero; c 0.
//   Logic/shift/illegal: v=0, c=0. n = result msb, z = ~|result always.
//  Output hold: while out_valid & ~out_ready, result and flags stay stable.
//   out_valid drops after the handshake unless a new response loads the same edge.
//  Simultaneous out_ready & in_valid (IDLE): drain and accept in the same cycle, no bubble.
//  Reset mid-MUL: asynchronous abort, no response ever issued for that request.
//  All arithmetic is modulo 2^WIDTH; no X is ever driven on result.
// STRUCTURE
//  alu_pkg: opcode localparams (ALU_AND..ALU_NOP), FSM state encoding,
//   flag index constants; shared with the ALU control decoder.
//  Sub-module alu_mul_iter (WIDTH): start/done iterative multiplier with
//   product-high-nonzero output. Everything else stays inline in alu_seq.
// TESTING  (WIDTH=32, MUL_EN=1, out_ready=1 unless noted)
//  ADD 0x7FFFFFFF+0x1 -> 0x80000000, v1 n1 z0 c0, out_valid 1 cycle after accept.
//  SUB 5-5 -> 0, z1 c1 v0; SLT 0x80000000,1 -> 1; SLTU 0x80000000,1 -> 0, c1.
//  MUL 0x10000*0x10000 -> 0, v1 z1; out_valid at +33 cycles; in_ready 0 for 32 cycles.
//  SRA 0x80000000 by 4 -> 0xF8000000 n1; SLL 1 by 31 -> 0x80000000.
//  out_ready 0 for 5 cycles after ADD 2+3 -> result 5 stable, in_ready 0; raise -> next op accepted same cycle.
//  reset pulse at cycle 10 of MUL -> out_valid 0 at once, no response;
//   NOP after ADD 2+3 -> 5 again; code 1110 -> result 0, z1, ill_flag 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag indices.
package alu_pkg;

    // Operation select codes driven by the ALU control decoder
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_MUL  = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_NAND = 4'b1100;
    localparam logic [3:0] ALU_XOR  = 4'b1101;
    localparam logic [3:0] ALU_NOP  = 4'b1111;

    // Control FSM: idle/single-cycle, or waiting on the iterative multiplier
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

    // Bit positions inside the registered flag vector
    localparam int FLAG_V    = 0;
    localparam int FLAG_N    = 1;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_C    = 3;
    localparam int NUM_FLAGS = 4;

    // True for every code the ALU implements; MUL only when the multiplier exists
    function automatic logic is_legal(input logic [3:0] code, input bit mul_en);
        logic legal;
        case (code)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SUB,
            ALU_SLT, ALU_NOR, ALU_SLTU, ALU_NAND, ALU_XOR, ALU_NOP: legal = 1'b1;
            ALU_MUL: legal = mul_en;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// o_product/o_high_nz/o_done are valid combinationally in the final iteration
// cycle so the caller can register the result on that same edge.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_product,
    output logic             o_high_nz
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_count;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign o_done     = r_busy & (r_count == LAST);
    assign o_product  = w_acc_next[WIDTH-1:0];
    assign o_high_nz  = |w_acc_next[2*WIDTH-1:WIDTH];

    // Load operands on start, then add the shifted multiplicand per multiplier bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_count  <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CW'(1);
            if (r_count == LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides. Single-cycle ops answer the
// cycle after accept; MUL runs through alu_mul_iter and answers WIDTH+1 later.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic [3:0]       i_alu_control_code,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_v_flag,
    output logic             o_n_flag,
    output logic             o_z_flag,
    output logic             o_c_flag,
    output logic             o_ill_flag
);
    localparam int SW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    alu_state_t             r_state, w_state_next;
    logic [WIDTH-1:0]       r_result;
    logic [NUM_FLAGS-1:0]   r_flags;
    logic                   r_ill, r_out_valid;

    logic                   w_accept, w_is_mul, w_mul_start, w_load;
    logic                   w_mul_done, w_mul_high_nz;
    logic [WIDTH-1:0]       w_mul_product;
    logic [WIDTH:0]         w_sum, w_diff;
    logic                   w_add_v, w_sub_v, w_sub_c;
    logic [SW-1:0]          w_shamt;
    logic [WIDTH-1:0]       w_res, w_load_res;
    logic                   w_v, w_c, w_load_v, w_load_c, w_load_ill;
    logic [NUM_FLAGS-1:0]   w_load_flags;

    assign o_in_ready  = (r_state == ST_IDLE) & (~r_out_valid | i_out_ready);
    assign w_accept    = i_in_valid & o_in_ready;
    assign w_is_mul    = (i_alu_control_code == ALU_MUL) & MUL_EN;
    assign w_mul_start = w_accept & w_is_mul;

    assign w_sum   = {1'b0, i_op1} + {1'b0, i_op2};
    assign w_diff  = {1'b0, i_op1} - {1'b0, i_op2};
    assign w_add_v = (i_op1[MSB] == i_op2[MSB]) & (w_sum[MSB] != i_op1[MSB]);
    assign w_sub_v = (i_op1[MSB] != i_op2[MSB]) & (w_diff[MSB] != i_op1[MSB]);
    assign w_sub_c = ~w_diff[WIDTH];
    assign w_shamt = i_op2[SW-1:0];

    generate
        if (MUL_EN) begin : g_mul
            alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
                .clk       (i_clk),
                .reset     (i_reset),
                .i_start   (w_mul_start),
                .i_a       (i_op1),
                .i_b       (i_op2),
                .o_done    (w_mul_done),
                .o_product (w_mul_product),
                .o_high_nz (w_mul_high_nz)
            );
        end else begin : g_no_mul
            assign w_mul_done    = 1'b0;
            assign w_mul_product = '0;
            assign w_mul_high_nz = 1'b0;
        end
    endgenerate

    // Single-cycle datapath: result plus overflow/carry for the selected op
    always_comb begin
        w_res = '0;
        w_v   = 1'b0;
        w_c   = 1'b0;
        case (i_alu_control_code)
            ALU_AND:  w_res = i_op1 & i_op2;
            ALU_OR:   w_res = i_op1 | i_op2;
            ALU_NOR:  w_res = ~(i_op1 | i_op2);
            ALU_NAND: w_res = ~(i_op1 & i_op2);
            ALU_XOR:  w_res = i_op1 ^ i_op2;
            ALU_SLL:  w_res = i_op1 << w_shamt;
            ALU_SRL:  w_res = i_op1 >> w_shamt;
            ALU_SRA:  w_res = $unsigned($signed(i_op1) >>> w_shamt);
            ALU_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_v   = w_add_v;
                w_c   = w_sum[WIDTH];
            end
            ALU_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_v   = w_sub_v;
                w_c   = w_sub_c;
            end
            // Signed less-than is the sign of the true difference: n ^ v
            ALU_SLT: begin
                w_res = {{(WIDTH-1){1'b0}}, w_diff[MSB] ^ w_sub_v};
                w_v   = w_sub_v;
                w_c   = w_sub_c;
            end
            ALU_SLTU: begin
                w_res = {{(WIDTH-1){1'b0}}, ~w_sub_c};
                w_v   = w_sub_v;
                w_c   = w_sub_c;
            end
            default: w_res = '0;
        endcase
    end

    // Select what gets registered: multiplier result, NOP replay, or datapath
    always_comb begin
        w_load_res = w_res;
        w_load_v   = w_v;
        w_load_c   = w_c;
        w_load_ill = ~is_legal(i_alu_control_code, MUL_EN);
        if (r_state == ST_MUL) begin
            w_load_res = w_mul_product;
            w_load_v   = w_mul_high_nz;
            w_load_c   = 1'b0;
            w_load_ill = 1'b0;
        end
        w_load_flags         = '0;
        w_load_flags[FLAG_V] = w_load_v;
        w_load_flags[FLAG_C] = w_load_c;
        w_load_flags[FLAG_N] = w_load_res[MSB];
        w_load_flags[FLAG_Z] = ~|w_load_res;
        if ((r_state == ST_IDLE) && (i_alu_control_code == ALU_NOP)) begin
            w_load_res   = r_result;
            w_load_flags = r_flags;
        end
    end

    // FSM state register; reset aborts any multiply in flight
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and output-register load strobe
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_state_next = ST_MUL;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (w_mul_done) begin
                    w_state_next = ST_IDLE;
                    w_load       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Response registers: load a new response, else drop valid once consumed
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_result    <= '0;
            r_flags     <= '0;
            r_ill       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_result    <= w_load_res;
            r_flags     <= w_load_flags;
            r_ill       <= w_load_ill;
            r_out_valid <= 1'b1;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_v_flag    = r_flags[FLAG_V];
    assign o_n_flag    = r_flags[FLAG_N];
    assign o_z_flag    = r_flags[FLAG_Z];
    assign o_c_flag    = r_flags[FLAG_C];
    assign o_ill_flag  = r_ill;

endmodule
